tcm_seq_ctrl: RTL and testbench
===============================

Name: tcm_seq_ctrl

Overview:
- Parametrised next-generation TCM timing controller, clocked from sysclk.
- Generates a divided serial bit clock (clk) and a free-running phase strobe (ps1) with programmable period and width.
- Runs an address-latch / serial-shift sequence: an ale strobe, then ADDR_W address bits on rmuadd, with start/busy/done handshake and an optional auto-repeat mode.
- Sits between the system sequencer and the RMU serial address interface.

Parameters:
- ADDR_W, 8, serial address width in bits (>=2).
- DIV, 4, sysclk cycles per bit period; must be even and >=2.
- PS_PERIOD, 8, bit periods per ps1 cycle (>=2).
- PS_HIGH, 1, bit periods ps1 is high per cycle (1..PS_PERIOD-1).
- MSB_FIRST, 1, 1 = shift out addr MSB first; 0 = LSB first.

Ports:
- sysclk, input, 1, sole clock; all logic on its rising edge.
- por, input, 1, reset; synchronous, active-high.
- start, input, 1, request one address frame; sampled only in IDLE.
- addr, input, ADDR_W, address captured when a frame is launched.
- repeat_en, input, 1, 1 = relaunch automatically after each frame.
- clk, output, 1, divided serial bit clock.
- ale, output, 1, address-latch strobe; high for exactly one bit period per frame.
- rmuadd, output, 1, serial address data.
- ps1, output, 1, periodic phase strobe.
- busy, output, 1, frame in progress.
- done, output, 1, one-sysclk pulse at end of each frame.

Behaviour:
- All outputs are registered.
- Reset (por=1 at an edge): every output 0 at the next edge, including clk, ale, rmuadd, ps1, busy and done. div_cnt=0, ps_cnt=PS_PERIOD-1, FSM=IDLE.
- Reset takes priority over all other inputs. Reset mid-frame aborts the frame with no done pulse.
- Divider: div_cnt counts 0..DIV-1 and wraps.
  - tick = (div_cnt==DIV-1).
  - clk=1 exactly while div_cnt is in DIV/2..DIV-1, giving a 50% duty cycle with period DIV.
  - Data and strobe changes occur on the edge after tick, i.e. at clk falling. Data is therefore stable at clk rising.
- ps1: on each tick, ps_cnt = (ps_cnt==PS_PERIOD-1) ? 0 : ps_cnt+1, and ps1 = (new ps_cnt < PS_HIGH).
  - Free-running and independent of the FSM.
  - The first tick after reset sets ps1=1.
- FSM states: IDLE, ARM, ALE, SHIFT.
  - IDLE: if start=1, capture addr into the shift register, busy=1, go to ARM. This can happen in any sysclk cycle; tick is not required. start in any other state is ignored.
  - ARM: wait for tick, then go to ALE with ale=1. This aligns the frame to the bit grid; the wait is 1..DIV cycles.
  - ALE: on tick, ale=0, rmuadd = first bit, go to SHIFT with bit_cnt=0.
  - SHIFT: on each tick with bit_cnt<ADDR_W-1, present the next bit and increment bit_cnt.
  - SHIFT, on the tick with bit_cnt==ADDR_W-1 (end of last bit): done=1 for that one sysclk cycle and rmuadd=0. Then:
    - if repeat_en=1: recapture addr, set ale=1, go to ALE. busy stays 1 with no gap.
    - else: busy=0, go to IDLE.
  - repeat_en is sampled only at that end-of-frame tick. Clearing it mid-frame lets the current frame finish.
- Bit order: MSB_FIRST=1 outputs addr[ADDR_W-1] down to addr[0]; MSB_FIRST=0 outputs addr[0] up to addr[ADDR_W-1].
- Each bit and the ale strobe are held exactly DIV sysclk cycles.
- Frame length: ale + ADDR_W bits = (ADDR_W+1)*DIV cycles, plus the ARM wait on launch from IDLE.
- rmuadd=0 and ale=0 whenever the FSM is in IDLE.
- Counter widths: use clog2 of each range. No overflow is possible; all counters wrap explicitly.

Test Plan:
- Reset: hold por=1 for 3 cycles mid-frame → all outputs 0 on the next edge, no done pulse. After release, clk period = 4 cycles (2 low, 2 high) and the first tick sets ps1=1.
- ps1 at defaults: after reset, ps1 is high for 4 sysclk cycles (1 bit period) and low for 28, repeating with a 32-cycle period.
- Single frame, addr=8'hA5, MSB_FIRST=1, repeat_en=0:
  - ale high for 4 cycles.
  - rmuadd then outputs 1,0,1,0,0,1,0,1, each held 4 cycles and changing at clk falling.
  - done pulses 1 cycle, busy falls the same edge, rmuadd returns to 0.
- LSB-first build (MSB_FIRST=0), addr=8'h01 → rmuadd outputs 1,0,0,0,0,0,0,0.
- Repeat: repeat_en=1, addr=8'h3C then changed to 8'hC3 during frame 1:
  - frame 2 starts ale immediately after done with no IDLE gap and shifts C3.
  - clear repeat_en during frame 2 → frame 2 completes, then the FSM goes IDLE.
- Start while busy: pulse start 3 times during a frame → ignored; exactly one done pulse. A start on the same cycle as done (repeat_en=0) is ignored, and a start the following cycle launches a new frame.

Source files
------------

// File: rtl/tcm_seq_ctrl.sv
`timescale 1ns/1ps
// tcm_seq_ctrl
// Timing controller for the RMU serial address interface. Divides sysclk
// down to a serial bit clock, generates a free-running phase strobe and runs
// the address-latch / serial-shift frame sequence.
//
// Ports:
//   sysclk     in   sole clock, rising edge
//   por        in   synchronous active-high reset
//   start      in   request one address frame (only honoured in IDLE)
//   addr       in   [ADDR_W] address captured at frame launch
//   repeat_en  in   relaunch automatically at the end of each frame
//   clk        out  divided serial bit clock, 50% duty, period DIV
//   ale        out  address-latch strobe, one bit period per frame
//   rmuadd     out  serial address data, changes at clk falling
//   ps1        out  periodic phase strobe
//   busy       out  frame in progress
//   done       out  one-sysclk pulse at the end of each frame
module tcm_seq_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DIV       = 4,
    parameter int PS_PERIOD = 8,
    parameter int PS_HIGH   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              sysclk,
    input  logic              por,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              repeat_en,
    output logic              clk,
    output logic              ale,
    output logic              rmuadd,
    output logic              ps1,
    output logic              busy,
    output logic              done
);
    localparam int DIV_W = $clog2(DIV);
    localparam int PS_W  = $clog2(PS_PERIOD);
    localparam int BIT_W = $clog2(ADDR_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PS_PERIOD - 1);
    localparam logic [PS_W-1:0]  PS_HI    = PS_W'(PS_HIGH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADDR_W - 1);

    typedef enum logic [1:0] {IDLE, ARM, ALE, SHIFT} state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
    logic [PS_W-1:0]   ps_cnt_reg, ps_cnt_next;
    logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [ADDR_W-1:0] sh_reg, sh_next;
    logic              clk_reg, clk_next;
    logic              ps1_reg, ps1_next;
    logic              ale_reg, ale_next;
    logic              rmuadd_reg, rmuadd_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              tick;

    // The shift register always emits its MSB; for LSB-first builds the
    // address is bit-reversed on capture so the shifter stays one-directional.
    logic [ADDR_W-1:0] addr_ord;
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_ord
            if (MSB_FIRST != 0) begin : g_msb
                assign addr_ord[gi] = addr[gi];
            end else begin : g_lsb
                assign addr_ord[gi] = addr[ADDR_W-1-gi];
            end
        end
    endgenerate

    // Bit-period divider and phase strobe. clk is registered from the next
    // divider value so it is high exactly while div_cnt is in the upper half.
    always_comb begin
        tick         = (div_cnt_reg == DIV_LAST);
        div_cnt_next = tick ? '0 : div_cnt_reg + DIV_W'(1);
        clk_next     = (div_cnt_next >= DIV_HALF);
        ps_cnt_next  = ps_cnt_reg;
        ps1_next     = ps1_reg;
        if (tick) begin
            ps_cnt_next = (ps_cnt_reg == PS_LAST) ? '0 : ps_cnt_reg + PS_W'(1);
            ps1_next    = (ps_cnt_next < PS_HI);
        end
    end

    // Frame sequencer. Every transition out of ARM/ALE/SHIFT happens on tick,
    // so data and strobes change on the edge where clk falls.
    always_comb begin
        state_next   = state_reg;
        sh_next      = sh_reg;
        bit_cnt_next = bit_cnt_reg;
        ale_next     = ale_reg;
        rmuadd_next  = rmuadd_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                ale_next    = 1'b0;
                rmuadd_next = 1'b0;
                if (start) begin
                    sh_next    = addr_ord;
                    busy_next  = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    ale_next   = 1'b1;
                    state_next = ALE;
                end
            end
            ALE: begin
                if (tick) begin
                    ale_next     = 1'b0;
                    rmuadd_next  = sh_reg[ADDR_W-1];
                    sh_next      = sh_reg << 1;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        done_next   = 1'b1;
                        rmuadd_next = 1'b0;
                        if (repeat_en) begin
                            // Back-to-back frame: straight into ALE, busy held.
                            sh_next    = addr_ord;
                            ale_next   = 1'b1;
                            state_next = ALE;
                        end else begin
                            busy_next  = 1'b0;
                            state_next = IDLE;
                        end
                    end else begin
                        rmuadd_next  = sh_reg[ADDR_W-1];
                        sh_next      = sh_reg << 1;
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (por) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            ps_cnt_reg  <= PS_LAST;
            bit_cnt_reg <= '0;
            sh_reg      <= '0;
            clk_reg     <= 1'b0;
            ps1_reg     <= 1'b0;
            ale_reg     <= 1'b0;
            rmuadd_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            ps_cnt_reg  <= ps_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            sh_reg      <= sh_next;
            clk_reg     <= clk_next;
            ps1_reg     <= ps1_next;
            ale_reg     <= ale_next;
            rmuadd_reg  <= rmuadd_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign clk    = clk_reg;
    assign ale    = ale_reg;
    assign rmuadd = rmuadd_reg;
    assign ps1    = ps1_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_tcm_seq_ctrl.sv
`timescale 1ns/1ps
// Testbench for tcm_seq_ctrl: an MSB-first and an LSB-first instance share
// the same stimulus; a slot-arithmetic reference model predicts every output.
module tb_tcm_seq_ctrl;
    localparam int AW        = 8;
    localparam int DIV       = 4;
    localparam int PS_PERIOD = 8;
    localparam int PS_HIGH   = 1;
    localparam int FRAME     = (AW + 1) * DIV;

    logic          sysclk = 1'b0;
    logic          por = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          repeat_en = 1'b0;
    logic clk_a, ale_a, rmuadd_a, ps1_a, busy_a, done_a;
    logic clk_b, ale_b, rmuadd_b, ps1_b, busy_b, done_b;

    tcm_seq_ctrl #(.ADDR_W(AW), .DIV(DIV), .PS_PERIOD(PS_PERIOD), .PS_HIGH(PS_HIGH), .MSB_FIRST(1)) dut (
        .sysclk(sysclk), .por(por), .start(start), .addr(addr), .repeat_en(repeat_en),
        .clk(clk_a), .ale(ale_a), .rmuadd(rmuadd_a), .ps1(ps1_a), .busy(busy_a), .done(done_a));

    tcm_seq_ctrl #(.ADDR_W(AW), .DIV(DIV), .PS_PERIOD(PS_PERIOD), .PS_HIGH(PS_HIGH), .MSB_FIRST(0)) dut_lsb (
        .sysclk(sysclk), .por(por), .start(start), .addr(addr), .repeat_en(repeat_en),
        .clk(clk_b), .ale(ale_b), .rmuadd(rmuadd_b), .ps1(ps1_b), .busy(busy_b), .done(done_b));

    always #5 sysclk = ~sysclk;

    logic [11:0] obs;
    assign obs = {clk_a, ale_a, rmuadd_a, ps1_a, busy_a, done_a,
                  clk_b, ale_b, rmuadd_b, ps1_b, busy_b, done_b};

    int tests = 0;
    int fails = 0;

    // Reference model: k = sysclk edges since reset; a frame is described by
    // the k at which ale rises and the address it carries.
    int            k = 0;
    bit            m_active = 0;
    int            m_ale_k = 0;
    logic [AW-1:0] m_addr = '0;
    bit            m_done = 0;
    logic [11:0]   exp_vec = '0;

    // Advance one clock edge and update the model with the inputs as they
    // were sampled at that edge. Outputs are read 1ns after the edge.
    task automatic step();
        logic          s_in, r_in, p_in;
        logic [AW-1:0] a_in;
        int            off, slot;
        logic          e_clk, e_ale, e_rm_m, e_rm_l, e_ps1;
        s_in = start;
        r_in = repeat_en;
        p_in = por;
        a_in = addr;
        @(posedge sysclk);
        #1;
        m_done = 0;
        if (p_in) begin
            k = 0;
            m_active = 0;
        end else begin
            k++;
            if (m_active && k == m_ale_k + FRAME) begin
                m_done = 1;
                if (r_in) begin
                    m_ale_k = k;
                    m_addr  = a_in;
                end else begin
                    m_active = 0;
                end
            end else if (!m_active && s_in) begin
                m_active = 1;
                m_addr   = a_in;
                m_ale_k  = (k / DIV + 1) * DIV;
            end
        end
        e_clk  = (k % DIV) >= DIV / 2;
        e_ps1  = ((PS_PERIOD - 1 + k / DIV) % PS_PERIOD) < PS_HIGH;
        e_ale  = 0;
        e_rm_m = 0;
        e_rm_l = 0;
        if (m_active && k >= m_ale_k) begin
            off  = k - m_ale_k;
            slot = off / DIV;
            if (slot == 0) begin
                e_ale = 1;
            end else if (slot <= AW) begin
                e_rm_m = m_addr[AW-slot];
                e_rm_l = m_addr[slot-1];
            end
        end
        exp_vec = {e_clk, e_ale, e_rm_m, e_ps1, m_active, m_done,
                   e_clk, e_ale, e_rm_l, e_ps1, m_active, m_done};
    endtask

    task automatic test_reset();
        logic [7:0] clk_exp = 8'b01100110;
        logic [7:0] ps1_exp = 8'b01111000;
        por = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (obs !== 12'b0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got %b, want all zero", i, obs);
            end
        end
        por = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            tests++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL reset_model k=%0d: got %b, want %b", k, obs, exp_vec);
            end
            tests++;
            if (clk_a !== clk_exp[i] || ps1_a !== ps1_exp[i]) begin
                fails++;
                $display("FAIL reset_clk_ps1 k=%0d: got clk=%b ps1=%b, want clk=%b ps1=%b",
                         k, clk_a, ps1_a, clk_exp[i], ps1_exp[i]);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_reset_midframe();
        int done_cnt = 0;
        addr = 8'h5F;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        tests++;
        if (busy_a !== 1'b1) begin
            fails++;
            $display("FAIL midframe_busy: got %b, want 1", busy_a);
        end
        por = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done_a === 1'b1) done_cnt++;
            tests++;
            if (obs !== 12'b0) begin
                fails++;
                $display("FAIL midframe_reset cycle %0d: got %b, want all zero", i, obs);
            end
        end
        por = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_a === 1'b1) done_cnt++;
            tests++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL midframe_model k=%0d: got %b, want %b", k, obs, exp_vec);
            end
        end
        tests++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL midframe_no_done: got %0d done pulses, want 0", done_cnt);
        end
        $display("[TB] test_reset_midframe done");
    endtask

    task automatic test_ps1();
        int highs = 0, rises = 0, first_rise = -1, second_rise = -1;
        logic prev = 1'b0;
        por = 1'b1;
        step();
        por = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            tests++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL ps1_model k=%0d: got %b, want %b", k, obs, exp_vec);
            end
            if (ps1_a === 1'b1) highs++;
            if (ps1_a === 1'b1 && prev === 1'b0) begin
                rises++;
                if (first_rise < 0) first_rise = i;
                else if (second_rise < 0) second_rise = i;
            end
            prev = ps1_a;
        end
        tests++;
        if (highs != 8 || rises != 2 || second_rise - first_rise != 32) begin
            fails++;
            $display("FAIL ps1_shape: got highs=%0d rises=%0d period=%0d, want 8 2 32",
                     highs, rises, second_rise - first_rise);
        end
        $display("[TB] test_ps1 done");
    endtask

    task automatic test_single();
        int c = -1, ale_cnt = 0, done_cnt = 0;
        logic [7:0] bits = '0;
        addr = 8'hA5;
        repeat_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        addr = 8'h00;
        for (int i = 0; i < 60; i++) begin
            step();
            tests++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL single_model k=%0d: got %b, want %b", k, obs, exp_vec);
            end
            if (c < 0 && ale_a === 1'b1) c = 0;
            else if (c >= 0) c++;
            if (ale_a === 1'b1) ale_cnt++;
            if (done_a === 1'b1) done_cnt++;
            if (c >= 4 && c < 36 && c % 4 == 1) bits = {bits[6:0], rmuadd_a};
            if (c == 36) begin
                tests++;
                if (done_a !== 1'b1 || busy_a !== 1'b0 || rmuadd_a !== 1'b0) begin
                    fails++;
                    $display("FAIL single_end: got done=%b busy=%b rmuadd=%b, want 1 0 0",
                             done_a, busy_a, rmuadd_a);
                end
            end
        end
        tests++;
        if (c < 36 || bits !== 8'hA5 || ale_cnt != 4 || done_cnt != 1) begin
            fails++;
            $display("FAIL single_frame: got bits=%h ale=%0d done=%0d c=%0d, want a5 4 1 >=36",
                     bits, ale_cnt, done_cnt, c);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_lsb();
        int c = -1;
        logic [7:0] bits_a = '0, bits_b = '0;
        addr = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            tests++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL lsb_model k=%0d: got %b, want %b", k, obs, exp_vec);
            end
            if (c < 0 && ale_b === 1'b1) c = 0;
            else if (c >= 0) c++;
            if (c >= 4 && c < 36 && c % 4 == 1) begin
                bits_a = {bits_a[6:0], rmuadd_a};
                bits_b = {bits_b[6:0], rmuadd_b};
            end
        end
        tests++;
        if (bits_b !== 8'h80 || bits_a !== 8'h01) begin
            fails++;
            $display("FAIL lsb_order: got lsb=%b msb=%b, want 10000000 00000001", bits_b, bits_a);
        end
        $display("[TB] test_lsb done");
    endtask

    task automatic test_back_to_back();
        int c = -1;
        logic [7:0] bits1 = '0, bits2 = '0;
        addr = 8'h3C;
        repeat_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            tests++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL repeat_model k=%0d: got %b, want %b", k, obs, exp_vec);
            end
            if (c < 0 && ale_a === 1'b1) c = 0;
            else if (c >= 0) c++;
            if (c == 2) addr = 8'hC3;
            if (c == 50) repeat_en = 1'b0;
            if (c >= 4 && c < 36 && c % 4 == 1) bits1 = {bits1[6:0], rmuadd_a};
            if (c >= 40 && c < 72 && c % 4 == 1) bits2 = {bits2[6:0], rmuadd_a};
            if (c == 36) begin
                tests++;
                if (done_a !== 1'b1 || ale_a !== 1'b1 || busy_a !== 1'b1) begin
                    fails++;
                    $display("FAIL repeat_gap: got done=%b ale=%b busy=%b, want 1 1 1",
                             done_a, ale_a, busy_a);
                end
            end
            if (c == 72) begin
                tests++;
                if (done_a !== 1'b1 || ale_a !== 1'b0 || busy_a !== 1'b0) begin
                    fails++;
                    $display("FAIL repeat_stop: got done=%b ale=%b busy=%b, want 1 0 0",
                             done_a, ale_a, busy_a);
                end
            end
        end
        tests++;
        if (c < 72 || bits1 !== 8'h3C || bits2 !== 8'hC3 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL repeat_frames: got f1=%h f2=%h busy=%b c=%0d, want 3c c3 0 >=72",
                     bits1, bits2, busy_a, c);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_start_busy();
        int c = -1, done_cnt = 0;
        addr = 8'h5A;
        repeat_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            tests++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL startbusy_model k=%0d: got %b, want %b", k, obs, exp_vec);
            end
            if (c < 0 && ale_a === 1'b1) c = 0;
            else if (c >= 0) c++;
            if (done_a === 1'b1 && c <= 37) done_cnt++;
            if (c == 36) begin
                tests++;
                if (done_a !== 1'b1 || busy_a !== 1'b0) begin
                    fails++;
                    $display("FAIL start_on_done: got done=%b busy=%b, want 1 0", done_a, busy_a);
                end
            end
            if (c == 37) begin
                tests++;
                if (busy_a !== 1'b1) begin
                    fails++;
                    $display("FAIL start_after_done: got busy=%b, want 1", busy_a);
                end
            end
            start = (c == 4 || c == 12 || c == 20 || c == 35 || c == 36);
        end
        start = 1'b0;
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL start_ignored: got %0d done pulses, want 1", done_cnt);
        end
        $display("[TB] test_start_busy done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            addr  = AW'($urandom);
            if ($urandom_range(0, 49) == 0) repeat_en = ~repeat_en;
            por   = ($urandom_range(0, 299) == 0);
            step();
            tests++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL random_model k=%0d: got %b, want %b", k, obs, exp_vec);
            end
        end
        por = 1'b0;
        start = 1'b0;
        repeat_en = 1'b0;
        $display("[TB] test_random done");
    endtask

    initial begin
        test_reset();
        test_ps1();
        test_single();
        test_lsb();
        test_back_to_back();
        test_start_busy();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
